// File: rtl/des_pkg.sv
// Shared widths, round limit and controller states
// for the iterative DES sequencer.
package des_pkg;

  localparam int DES_BLK_W = 64;
  localparam int DES_KEY_W = 56;

  localparam logic [3:0] DES_LAST_ROUND = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_state_e;

endpackage

// File: rtl/des_round_ctrl.sv
// Sequencer for the 16-round iterative DES core: holds the block on the
// core inputs, steps roundSel, captures the result and counts handoffs.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DES_BLK_W-1:0] in_data,
  input  logic [DES_KEY_W-1:0] in_key,
  input  logic                 in_decrypt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DES_BLK_W-1:0] out_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     blk_cnt,
  output logic [DES_BLK_W-1:0] core_desIn,
  output logic [DES_KEY_W-1:0] core_key,
  output logic                 core_decrypt,
  output logic [3:0]           core_roundSel,
  input  logic [DES_BLK_W-1:0] core_desOut
);

  des_state_e           state_q, state_d;
  logic [3:0]           round_q, round_d;
  logic [DES_BLK_W-1:0] din_q, din_d;
  logic [DES_BLK_W-1:0] dout_q, dout_d;
  logic [DES_KEY_W-1:0] key_q, key_d;
  logic                 dec_q, dec_d;
  logic                 ovld_q, ovld_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept;
  logic                 handoff;

  assign in_ready = (state_q == IDLE)
                  | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign handoff  = ovld_q & out_ready;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    din_d   = din_q;
    key_d   = key_q;
    dec_d   = dec_q;
    dout_d  = dout_q;
    ovld_d  = ovld_q;
    cnt_d   = cnt_q;

    if (handoff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        round_d = 4'd0;
      end
      RUN: begin
        if (round_q == DES_LAST_ROUND) begin
          dout_d  = core_desOut;
          ovld_d  = 1'b1;
          round_d = 4'd0;
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (handoff) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ovld_d  = 1'b0;
        round_d = 4'd0;
        state_d = IDLE;
      end
    endcase

    // A new block may land in the same cycle as a handoff.
    if (accept) begin
      din_d   = in_data;
      key_d   = in_key;
      dec_d   = in_decrypt;
      round_d = 4'd0;
      ovld_d  = 1'b0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      din_q   <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      dout_q  <= '0;
      ovld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      din_q   <= din_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
      ovld_q  <= ovld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = ovld_q;
  assign out_data      = dout_q;
  assign busy          = (state_q != IDLE);
  assign blk_cnt       = cnt_q;
  assign core_desIn    = din_q;
  assign core_key      = key_q;
  assign core_decrypt  = dec_q;
  assign core_roundSel = round_q;

endmodule
